// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Start/Busy/Done handshake. The result is held until the next conversion
// completes.
// Optional leading-zero blank mask: define LEADING_ZERO_BLANK_EN.
// Without that macro, Blank is tied to zero and no blank logic is built.
module bin_to_bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  Clock,
  input  logic                  Resetn,
  input  logic                  Start,
  input  logic [WIDTH-1:0]      Bin,
  output logic                  Busy,
  output logic                  Done,
  output logic [4*DIGITS-1:0]   BCD,
  output logic                  Overflow,
  output logic [DIGITS-1:0]     Blank
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state, state_nxt;
  logic [BW-1:0]   scr;
  logic [WIDTH-1:0] shr;
  logic [CW-1:0]   cnt;
  logic            ovf_sticky;

  logic [BW-1:0]   adj;
  logic [BW-1:0]   scr_nxt;
  logic            out_bit;
  logic            last;

  // Add 3 to every digit that is 5 or more, so the following shift carries correctly.
  function automatic logic [BW-1:0] add3(input logic [BW-1:0] s);
    logic [BW-1:0] r;
    r = s;
    for (int i = 0; i < DIGITS; i++) begin
      if (s[4*i +: 4] >= 4'd5) r[4*i +: 4] = s[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Next scratch value: adjust, then shift in the top bit of the binary operand.
  always_comb begin
    adj     = add3(scr);
    out_bit = adj[BW-1];
    scr_nxt = {adj[BW-2:0], shr[WIDTH-1]};
    last    = (cnt == CW'(1));
  end

  // State register.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic. Start is only looked at in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Start) state_nxt = SHIFT;
      SHIFT:   if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state.
  always_comb begin
    Busy = (state == SHIFT);
    Done = (state == DONE);
  end

  // Datapath: capture on accept, iterate in SHIFT, and publish on the last shift.
  // A reset clears the held result, so an aborted conversion leaves zeros.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      shr        <= '0;
      scr        <= '0;
      cnt        <= '0;
      ovf_sticky <= 1'b0;
      BCD        <= '0;
      Overflow   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            shr        <= Bin;
            scr        <= '0;
            cnt        <= CW'(WIDTH);
            ovf_sticky <= 1'b0;
          end
        end
        SHIFT: begin
          scr        <= scr_nxt;
          shr        <= {shr[WIDTH-2:0], 1'b0};
          cnt        <= cnt - CW'(1);
          ovf_sticky <= ovf_sticky | out_bit;
          if (last) begin
            BCD      <= scr_nxt;
            Overflow <= ovf_sticky | out_bit;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // A digit above the units is blanked when it and every higher digit are zero.
  function automatic logic [DIGITS-1:0] blank_mask(input logic [BW-1:0] s);
    logic [DIGITS-1:0] m;
    logic              z;
    m = '0;
    z = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      z    = z & (s[4*i +: 4] == 4'd0);
      m[i] = z;
    end
    return m;
  endfunction

  // The blank mask is loaded together with the BCD result.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn)                  Blank <= '0;
    else if (state == SHIFT && last) Blank <= blank_mask(scr_nxt);
  end
`else
  assign Blank = '0;
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed testbench for bin_to_bcd_seq. The first instance uses the default
// parameters (WIDTH=8, DIGITS=3). The second instance uses DIGITS=2 and shares
// the same Start/Bin, so it can show the overflow behaviour.
module tb_bin_to_bcd_seq;

  logic        Clock = 1'b0;
  logic        Resetn = 1'b0;
  logic        Start = 1'b0;
  logic [7:0]  Bin = 8'd0;

  logic        Busy, Done, Overflow;
  logic [11:0] BCD;
  logic [2:0]  Blank;

  logic        Busy2, Done2, Overflow2;
  logic [7:0]  BCD2;
  logic [1:0]  Blank2;

  int n_vec = 0;
  int n_bad = 0;

  bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) u_dut (
    .Clock(Clock), .Resetn(Resetn), .Start(Start), .Bin(Bin),
    .Busy(Busy), .Done(Done), .BCD(BCD), .Overflow(Overflow), .Blank(Blank)
  );

  bin_to_bcd_seq #(.WIDTH(8), .DIGITS(2)) u_dut2 (
    .Clock(Clock), .Resetn(Resetn), .Start(Start), .Bin(Bin),
    .Busy(Busy2), .Done(Done2), .BCD(BCD2), .Overflow(Overflow2), .Blank(Blank2)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One conversion on the default instance, with its timing checked on every cycle.
  task automatic convert(input logic [7:0] v, input logic [11:0] exp_bcd,
                         input logic [11:0] prev_bcd);
    @(negedge Clock);
    Start = 1'b1;
    Bin   = v;
    @(posedge Clock);
    #1;
    Start = 1'b0;
    Bin   = 8'($urandom);
    for (int i = 0; i < 8; i++) begin
      @(negedge Clock);
      chk("busy_shift", 32'(Busy), 32'(1'b1));
      chk("done_shift", 32'(Done), 32'(1'b0));
      if (i == 4) chk("bcd_hold", 32'(BCD), 32'(prev_bcd));
    end
    @(negedge Clock);
    chk("done_pulse", 32'(Done), 32'(1'b1));
    chk("busy_done", 32'(Busy), 32'(1'b0));
    chk("bcd", 32'(BCD), 32'(exp_bcd));
    chk("ovf", 32'(Overflow), 32'(1'b0));
    @(negedge Clock);
    chk("done_low", 32'(Done), 32'(1'b0));
  endtask

  initial begin
    int pulses;
    int first_at;
    int gap_bad;

    // Reset held: outputs stay at zero whatever Start and Bin do.
    for (int i = 0; i < 4; i++) begin
      @(negedge Clock);
      Start = 1'($urandom);
      Bin   = 8'($urandom);
      #1;
      chk("rst_bcd", 32'(BCD), 32'(12'h000));
      chk("rst_busy", 32'(Busy), 32'(1'b0));
      chk("rst_done", 32'(Done), 32'(1'b0));
      chk("rst_ovf", 32'(Overflow), 32'(1'b0));
      chk("rst_blank", 32'(Blank), 32'(3'b000));
      chk("rst_bcd2", 32'(BCD2), 32'(8'h00));
    end
    @(negedge Clock);
    Start  = 1'b0;
    Resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      chk("idle_bcd", 32'(BCD), 32'(12'h000));
      chk("idle_busy", 32'(Busy), 32'(1'b0));
      chk("idle_done", 32'(Done), 32'(1'b0));
    end

    // Basic conversions.
    convert(8'd255, 12'h255, 12'h000);
    chk("bcd2_255", 32'(BCD2), 32'(8'h55));
    chk("ovf2_255", 32'(Overflow2), 32'(1'b1));
    convert(8'd0,   12'h000, 12'h255);
    chk("ovf2_0", 32'(Overflow2), 32'(1'b0));
    convert(8'd99,  12'h099, 12'h000);
    convert(8'd137, 12'h137, 12'h099);

    // A Start pulse during SHIFT is ignored: exactly one Done, and the first value is kept.
    @(negedge Clock);
    Start = 1'b1;
    Bin   = 8'd99;
    @(negedge Clock);
    Start = 1'b0;
    @(negedge Clock);
    @(negedge Clock);
    Start = 1'b1;
    Bin   = 8'd5;
    @(negedge Clock);
    Start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clock);
      if (Done) pulses++;
    end
    chk("ignore_pulses", 32'(pulses), 32'd1);
    chk("ignore_bcd", 32'(BCD), 32'(12'h099));

    // Leading-zero blank mask.
    convert(8'd7, 12'h007, 12'h099);
`ifdef LEADING_ZERO_BLANK_EN
    chk("blank_7", 32'(Blank), 32'(3'b110));
`else
    chk("blank_off", 32'(Blank), 32'(3'b000));
`endif
    convert(8'd0, 12'h000, 12'h007);
`ifdef LEADING_ZERO_BLANK_EN
    chk("blank_0", 32'(Blank), 32'(3'b110));
`else
    chk("blank_off0", 32'(Blank), 32'(3'b000));
`endif
    convert(8'd100, 12'h100, 12'h000);
    chk("blank_100", 32'(Blank), 32'(3'b000));

    // Start held high: conversions repeat every 10 cycles.
    @(negedge Clock);
    Start = 1'b1;
    Bin   = 8'd42;
    @(posedge Clock);
    pulses   = 0;
    first_at = -1;
    gap_bad  = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge Clock);
      if (i == 29) Start = 1'b0;
      if (i == 0) chk("b2b_busy0", 32'(Busy), 32'(1'b1));
      if (i == 9) chk("b2b_busy9", 32'(Busy), 32'(1'b0));
      if (Done) begin
        chk("b2b_bcd", 32'(BCD), 32'(12'h042));
        if (first_at < 0) first_at = i;
        else if (i != first_at + 10 * pulses) gap_bad++;
        pulses++;
      end
    end
    chk("b2b_pulses", 32'(pulses), 32'd3);
    chk("b2b_first", 32'(first_at), 32'd8);
    chk("b2b_gap", 32'(gap_bad), 32'd0);

    // An asynchronous reset mid-conversion aborts it and clears the held result.
    @(negedge Clock);
    Start = 1'b1;
    Bin   = 8'd200;
    @(posedge Clock);
    #1;
    Start = 1'b0;
    repeat (3) @(negedge Clock);
    #1;
    Resetn = 1'b0;
    #1;
    chk("abort_bcd", 32'(BCD), 32'(12'h000));
    chk("abort_busy", 32'(Busy), 32'(1'b0));
    chk("abort_done", 32'(Done), 32'(1'b0));
    chk("abort_bcd2", 32'(BCD2), 32'(8'h00));
    repeat (2) @(negedge Clock);
    Resetn = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge Clock);
      if (Done) pulses++;
    end
    chk("abort_nodone", 32'(pulses), 32'd0);

    // Convert again after the abort; the two-digit instance overflows.
    convert(8'd200, 12'h200, 12'h000);
    chk("bcd2_200", 32'(BCD2), 32'(8'h00));
    chk("ovf2_200", 32'(Overflow2), 32'(1'b1));
    convert(8'd57, 12'h057, 12'h200);
    chk("bcd2_57", 32'(BCD2), 32'(8'h57));
    chk("ovf2_57", 32'(Overflow2), 32'(1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
